tanimoto_comparator: RTL and testbench

Final decision stage of the Tanimoto fingerprint-similarity pipeline. Takes the popcounts |A|, |B| and |A∧B| of a fingerprint pair and checks them against a threshold table stored in on-chip RAM. The table is indexed by |A|+|B|. Downstream logic receives a one-bit pass/fail flag with a valid qualifier.

---
 rtl/tanimoto_pkg.sv | 15 +
 rtl/tanimoto_comparator_if.sv | 34 +++
 rtl/tanimoto_comparator_threshold_ram.sv | 28 ++
 rtl/tanimoto_comparator.sv | 92 +++++++++
 tb/tb_tanimoto_comparator.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tanimoto_pkg.sv
// Shared widths and helpers for the Tanimoto comparator.
// Widths derive from the fingerprint length in bits.
package tanimoto_pkg;

    localparam int VECTOR_WIDTH_DEF = 35;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_WIDTH = cnt_width(VECTOR_WIDTH_DEF);
    localparam int SUM_WIDTH = CNT_WIDTH + 1;
    localparam int RAM_DEPTH = 2 ** SUM_WIDTH;

endpackage

// File: rtl/tanimoto_comparator_if.sv
// Count-triple input, threshold-RAM write port and pass/fail result
// of the Tanimoto comparator, bundled as one interface.
interface tanimoto_comparator_if
    import tanimoto_pkg::*;
#(
    parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF
);
    localparam int CW = cnt_width(VECTOR_WIDTH);
    localparam int SW = CW + 1;

    logic [CW-1:0] i_CntA;
    logic [CW-1:0] i_CntB;
    logic [CW-1:0] i_CntC;
    logic          i_Valid;
    logic [SW-1:0] i_BRAM_Addr;
    logic [SW-1:0] i_BRAM_Din;
    logic          i_BRAM_WrEn;
    logic          i_BRAM_En;
    logic          o_Dout;
    logic          o_Valid;

    modport master (
        output i_CntA, i_CntB, i_CntC, i_Valid,
        output i_BRAM_Addr, i_BRAM_Din, i_BRAM_WrEn, i_BRAM_En,
        input  o_Dout, o_Valid
    );

    modport slave (
        input  i_CntA, i_CntB, i_CntC, i_Valid,
        input  i_BRAM_Addr, i_BRAM_Din, i_BRAM_WrEn, i_BRAM_En,
        output o_Dout, o_Valid
    );

endinterface

// File: rtl/tanimoto_comparator_threshold_ram.sv
// Simple dual-port threshold table: synchronous read-first read,
// no reset on contents so it maps onto block RAM.
module threshold_ram #(
    parameter int SUM_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [SUM_WIDTH-1:0] wr_addr,
    input  logic [SUM_WIDTH-1:0] wr_data,
    input  logic [SUM_WIDTH-1:0] rd_addr,
    output logic [SUM_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 2 ** SUM_WIDTH;

    logic [SUM_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Separate read process: a same-address write returns the old entry
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tanimoto_comparator.sv
// Tanimoto decision stage: pass = C >= table[A+B], 3-cycle latency.
// TANIMOTO_CMP_OUTREG_EN adds one output register (latency 4).
module tanimoto_comparator
    import tanimoto_pkg::*;
#(
    parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    tanimoto_comparator_if.slave bus
);
    localparam int CW = cnt_width(VECTOR_WIDTH);
    localparam int SW = CW + 1;

    logic [SW-1:0] sum_s1;
    logic [SW-1:0] c_s1;
    logic [SW-1:0] c_s2;
    logic [SW-1:0] thr_s2;
    logic          v_s1;
    logic          v_s2;
    logic          v_s3;
    logic          d_s3;
    logic          pass;
    logic          wr_en;

    assign wr_en = bus.i_BRAM_En & bus.i_BRAM_WrEn;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_s1 <= 1'b0;
        end else begin
            v_s1 <= bus.i_Valid;
        end
        sum_s1 <= {1'b0, bus.i_CntA} + {1'b0, bus.i_CntB};
        c_s1   <= {1'b0, bus.i_CntC};
    end

    threshold_ram #(
        .SUM_WIDTH(SW)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(bus.i_BRAM_Addr),
        .wr_data(bus.i_BRAM_Din),
        .rd_addr(sum_s1),
        .rd_data(thr_s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v_s2 <= 1'b0;
        end else begin
            v_s2 <= v_s1;
        end
        c_s2 <= c_s1;
    end

    // Gating with valid keeps the flag low in bubble cycles
    assign pass = v_s2 && (c_s2 >= thr_s2);

    always_ff @(posedge clk) begin
        if (rst) begin
            v_s3 <= 1'b0;
            d_s3 <= 1'b0;
        end else begin
            v_s3 <= v_s2;
            d_s3 <= pass;
        end
    end

`ifdef TANIMOTO_CMP_OUTREG_EN
    logic v_s4;
    logic d_s4;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_s4 <= 1'b0;
            d_s4 <= 1'b0;
        end else begin
            v_s4 <= v_s3;
            d_s4 <= d_s3;
        end
    end

    assign bus.o_Valid = v_s4;
    assign bus.o_Dout  = d_s4;
`else
    assign bus.o_Valid = v_s3;
    assign bus.o_Dout  = d_s3;
`endif

endmodule

// File: tb/tb_tanimoto_comparator.sv
// Self-checking bench for tanimoto_comparator: randomized and directed
// triples checked against a cycle-stamped table/threshold model.
module tb_tanimoto_comparator;
    import tanimoto_pkg::*;

`ifdef TANIMOTO_CMP_OUTREG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    tanimoto_comparator_if bus ();

    tanimoto_comparator dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int ram_m [RAM_DEPTH];
    // expected result keyed by the cycle in which it must be visible
    bit exp_map [int];

    function automatic bit exp_v(input int c);
        return exp_map.exists(c);
    endfunction

    function automatic bit exp_d(input int c);
        return exp_map.exists(c) ? exp_map[c] : 1'b0;
    endfunction

    task automatic drive(input bit v, input int a, input int b, input int c);
        bus.i_Valid = v;
        bus.i_CntA  = CNT_WIDTH'(a);
        bus.i_CntB  = CNT_WIDTH'(b);
        bus.i_CntC  = CNT_WIDTH'(c);
    endtask

    task automatic wr(input bit en, input bit we, input int addr, input int din);
        bus.i_BRAM_En   = en;
        bus.i_BRAM_WrEn = we;
        bus.i_BRAM_Addr = SUM_WIDTH'(addr);
        bus.i_BRAM_Din  = SUM_WIDTH'(din);
    endtask

    // Advance one cycle, applying the reference rules to this cycle's inputs
    task automatic tick();
        int s;
        @(posedge clk);
        if (bus.i_BRAM_En && bus.i_BRAM_WrEn)
            ram_m[int'(bus.i_BRAM_Addr)] = int'(bus.i_BRAM_Din);
        if (rst) begin
            for (int k = 1; k <= LAT; k++) exp_map.delete(cyc + k);
        end else if (bus.i_Valid) begin
            s = int'(bus.i_CntA) + int'(bus.i_CntB);
            exp_map[cyc + LAT] = (int'(bus.i_CntC) >= ram_m[s]);
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom_range(35), $urandom_range(35), $urandom_range(35));
            tick();
            n_checks++;
            if (bus.o_Valid !== 1'b0 || bus.o_Dout !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d valid=%b dout=%b want 0/0",
                         cyc, bus.o_Valid, bus.o_Dout);
            end
        end
        rst = 1'b0;
        drive(1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.o_Valid !== 1'b0 || bus.o_Dout !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d valid=%b dout=%b want 0/0",
                         cyc, bus.o_Valid, bus.o_Dout);
            end
        end
    endtask

    task automatic test_identity();
        int a [3] = '{3, 20, 33};
        int b [3] = '{4, 1, 2};
        int c [3] = '{3, 20, 35};
        int t0;
        drive(1'b0, 0, 0, 0);
        for (int k = 0; k < RAM_DEPTH; k++) begin
            wr(1'b1, 1'b1, k, (k <= 70) ? k : 0);
            tick();
        end
        wr(1'b0, 1'b0, 0, 0);
        t0 = cyc;
        for (int i = 0; i < 3 + LAT + 1; i++) begin
            if (i < 3) drive(1'b1, a[i], b[i], c[i]);
            else drive(1'b0, 0, 0, 0);
            tick();
            n_checks++;
            if (bus.o_Valid !== exp_v(cyc)) begin
                n_fail++;
                $display("FAIL identity_valid cyc=%0d got=%b want=%b",
                         cyc, bus.o_Valid, exp_v(cyc));
            end
            n_checks++;
            if (bus.o_Dout !== exp_d(cyc)) begin
                n_fail++;
                $display("FAIL identity_dout cyc=%0d got=%b want=%b",
                         cyc, bus.o_Dout, exp_d(cyc));
            end
        end
        // Hard anchor: the third triple passes, the first two do not
        n_checks++;
        if (exp_d(t0 + LAT) !== 1'b0 || exp_d(t0 + LAT + 2) !== 1'b1) begin
            n_fail++;
            $display("FAIL identity_model got=%b%b want=01",
                     exp_d(t0 + LAT), exp_d(t0 + LAT + 2));
        end
    endtask

    task automatic test_boundaries();
        int addr [3] = '{0, 70, 70};
        int din  [3] = '{0, 36, 35};
        int cnt  [3] = '{0, 35, 35};
        bit want [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 0, 0);
            wr(1'b1, 1'b1, addr[i], din[i]);
            tick();
            wr(1'b0, 1'b0, 0, 0);
            drive(1'b1, cnt[i], cnt[i], cnt[i]);
            tick();
            drive(1'b0, 0, 0, 0);
            for (int j = 1; j < LAT; j++) tick();
            n_checks++;
            if (bus.o_Valid !== 1'b1 || bus.o_Dout !== want[i]) begin
                n_fail++;
                $display("FAIL boundary_%0d valid=%b dout=%b want 1/%b",
                         i, bus.o_Valid, bus.o_Dout, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_bubbles();
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5 + LAT + 1; i++) begin
            if (i < 5) drive(pat[i], $urandom_range(35), $urandom_range(35),
                             $urandom_range(35));
            else drive(1'b0, 0, 0, 0);
            tick();
            n_checks++;
            if (bus.o_Valid !== exp_v(cyc)) begin
                n_fail++;
                $display("FAIL bubble_valid cyc=%0d got=%b want=%b",
                         cyc, bus.o_Valid, exp_v(cyc));
            end
            n_checks++;
            if (bus.o_Dout !== exp_d(cyc)) begin
                n_fail++;
                $display("FAIL bubble_dout cyc=%0d got=%b want=%b",
                         cyc, bus.o_Dout, exp_d(cyc));
            end
        end
    endtask

    task automatic test_collision();
        bit want [2] = '{1'b0, 1'b1};
        wr(1'b1, 1'b1, 7, 7);
        drive(1'b0, 0, 0, 0);
        tick();
        wr(1'b0, 1'b0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 3, 4, 3);
            tick();
            drive(1'b0, 0, 0, 0);
            if (r == 0) wr(1'b1, 1'b1, 7, 2);
            tick();
            wr(1'b0, 1'b0, 0, 0);
            for (int j = 2; j < LAT; j++) tick();
            n_checks++;
            if (bus.o_Valid !== 1'b1 || bus.o_Dout !== want[r]) begin
                n_fail++;
                $display("FAIL collision_%0d valid=%b dout=%b want 1/%b",
                         r, bus.o_Valid, bus.o_Dout, want[r]);
            end
            n_checks++;
            if (bus.o_Dout !== exp_d(cyc)) begin
                n_fail++;
                $display("FAIL collision_model_%0d got=%b want=%b",
                         r, bus.o_Dout, exp_d(cyc));
            end
            tick();
        end
    endtask

    task automatic test_midreset();
        int t_next;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10 + i, 10, 35);
            rst = (i == 2);
            tick();
        end
        rst = 1'b0;
        drive(1'b1, 5, 5, 35);
        tick();
        t_next = cyc - 1;
        drive(1'b0, 0, 0, 0);
        for (int i = 0; i < LAT + 2; i++) begin
            n_checks++;
            if (bus.o_Valid !== (cyc == t_next + LAT)) begin
                n_fail++;
                $display("FAIL midreset_valid cyc=%0d got=%b want=%b",
                         cyc, bus.o_Valid, (cyc == t_next + LAT));
            end
            n_checks++;
            if (bus.o_Dout !== exp_d(cyc)) begin
                n_fail++;
                $display("FAIL midreset_dout cyc=%0d got=%b want=%b",
                         cyc, bus.o_Dout, exp_d(cyc));
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(39) == 0);
            drive($urandom_range(3) != 0, $urandom_range(35),
                  $urandom_range(35), $urandom_range(35));
            wr($urandom_range(1), $urandom_range(1),
               $urandom_range(RAM_DEPTH - 1), $urandom_range(RAM_DEPTH - 1));
            tick();
            n_checks++;
            if (bus.o_Valid !== exp_v(cyc)) begin
                n_fail++;
                $display("FAIL random_valid cyc=%0d got=%b want=%b",
                         cyc, bus.o_Valid, exp_v(cyc));
            end
            n_checks++;
            if (bus.o_Dout !== exp_d(cyc)) begin
                n_fail++;
                $display("FAIL random_dout cyc=%0d got=%b want=%b",
                         cyc, bus.o_Dout, exp_d(cyc));
            end
        end
        rst = 1'b0;
        drive(1'b0, 0, 0, 0);
        wr(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        drive(1'b0, 0, 0, 0);
        wr(1'b0, 1'b0, 0, 0);
        for (int k = 0; k < RAM_DEPTH; k++) ram_m[k] = 0;
        test_reset();
        test_identity();
        test_boundaries();
        test_bubbles();
        test_collision();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
